// File: rtl/hexdump_line_formatter.sv
// Byte-stream to ASCII hexdump converter: "OOOO: XX XX ... \r\n", one character
// per out_strobe, paced by the transmitter's ready signal.
module hexdump_line_formatter #(
  parameter int BYTES_PER_LINE = 16,
  parameter int ADDR_DIGITS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_strobe,
  input  logic       out_ready,
  output logic       busy
);

  localparam int AW = ADDR_DIGITS * 4;
  localparam int CW = $clog2(BYTES_PER_LINE + 1);
  localparam int DW = (ADDR_DIGITS > 1) ? $clog2(ADDR_DIGITS) : 1;

  typedef enum logic [3:0] {IDLE, ADDR, COLON, SPC0, HI, LO, SEP, CR, LF} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  col_reg, col_next;
  logic [AW-1:0]  offset_reg, offset_next;
  logic [AW-1:0]  line_off_reg, line_off_next;
  logic [7:0]     byte_reg, byte_next;
  logic [DW-1:0]  dig_reg, dig_next;
  logic [7:0]     out_data_reg, out_data_next;
  logic           out_strobe_reg, out_strobe_next;
  logic           run_reg;

  logic [AW-1:0]  addr_shift;
  logic [7:0]     char_sel;
  logic           emit;
  logic           flush_req;
  logic           accept;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Flush of a partial line wins over a byte offered in the same cycle.
  assign flush_req  = (state_reg == IDLE) && flush && (col_reg != '0);
  assign in_ready   = (state_reg == IDLE) && run_reg && !flush_req;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_reg != IDLE);
  assign out_data   = out_data_reg;
  assign out_strobe = out_strobe_reg;
  assign addr_shift = line_off_reg >> {dig_reg, 2'b00};

  // Every non-idle state emits one character; the strobe gap covers uart_tx ready latency.
  assign emit = (state_reg != IDLE) && out_ready && !out_strobe_reg;

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    offset_next   = offset_reg;
    line_off_next = line_off_reg;
    byte_next     = byte_reg;
    dig_next      = dig_reg;
    char_sel      = 8'h00;

    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next = CR;
        end else if (accept) begin
          byte_next   = in_data;
          offset_next = offset_reg + AW'(1);
          if (col_reg == '0) begin
            line_off_next = offset_reg;
            dig_next      = DW'(ADDR_DIGITS - 1);
            state_next    = ADDR;
          end else begin
            state_next = HI;
          end
        end
      end
      ADDR: begin
        char_sel = hex_char(addr_shift[3:0]);
        if (emit) begin
          if (dig_reg == '0) state_next = COLON;
          else               dig_next   = dig_reg - 1'b1;
        end
      end
      COLON: begin
        char_sel = 8'h3A;
        if (emit) state_next = SPC0;
      end
      SPC0: begin
        char_sel = 8'h20;
        if (emit) state_next = HI;
      end
      HI: begin
        char_sel = hex_char(byte_reg[7:4]);
        if (emit) state_next = LO;
      end
      LO: begin
        char_sel = hex_char(byte_reg[3:0]);
        if (emit) state_next = SEP;
      end
      SEP: begin
        char_sel = 8'h20;
        if (emit) begin
          col_next   = col_reg + 1'b1;
          state_next = (col_reg + 1'b1 == CW'(BYTES_PER_LINE)) ? CR : IDLE;
        end
      end
      CR: begin
        char_sel = 8'h0D;
        if (emit) state_next = LF;
      end
      LF: begin
        char_sel = 8'h0A;
        if (emit) begin
          col_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    out_strobe_next = emit;
    out_data_next   = emit ? char_sel : out_data_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      offset_reg     <= '0;
      line_off_reg   <= '0;
      byte_reg       <= '0;
      dig_reg        <= '0;
      out_data_reg   <= 8'h00;
      out_strobe_reg <= 1'b0;
      run_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      offset_reg     <= offset_next;
      line_off_reg   <= line_off_next;
      byte_reg       <= byte_next;
      dig_reg        <= dig_next;
      out_data_reg   <= out_data_next;
      out_strobe_reg <= out_strobe_next;
      run_reg        <= 1'b1;
    end
  end

endmodule
